alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU (ALUConf/Sign/in1/in2 -> result/relation) among NUM_REQ requesters
//  (e.g. EX-stage, branch-compare unit, address-gen helper). Round-robin grant, valid/ready request
//  and response handshakes, operands and result registered. Sits between the requesters and the ALU.
// PARAMETERS
//  NUM_REQ  2  number of requesters (2..8); IDW = $clog2(NUM_REQ), minimum 1
// PORTS
//  clk            in   1          single clock, all state on posedge
//  reset          in   1          synchronous, active-low reset
//  req_valid      in   NUM_REQ    per-requester request valid
//  req_ready      out  NUM_REQ    one-hot grant; transfer when req_valid[i] & req_ready[i]
//  req_conf       in   5*NUM_REQ  ALUConf per requester, slice i = [5*i+4:5*i]
//  req_sign       in   NUM_REQ    Sign per requester
//  req_in1        in   32*NUM_REQ in1 per requester
//  req_in2        in   32*NUM_REQ in2 per requester
//  alu_conf       out  5          to ALU ALUConf (registered)
//  alu_sign       out  1          to ALU Sign (registered)
//  alu_in1        out  32         to ALU in1 (registered)
//  alu_in2        out  32         to ALU in2 (registered)
//  alu_result     in   32         from ALU result
//  alu_relation   in   2          from ALU relation (00 <, 01 >, 10 =)
//  resp_valid     out  NUM_REQ    one-hot, response for requester i
//  resp_ready     in   NUM_REQ    requester i accepts response
//  resp_result    out  32         latched ALU result
//  resp_relation  out  2          latched ALU relation
//  resp_id        out  IDW        index of requester owning the response
// BEHAVIOUR
//  - FSM: IDLE -> EXEC -> RESP -> IDLE. Reset (reset==0 at posedge): state=IDLE, rr_ptr=0,
//    req_ready=0, resp_valid=0, resp_result=0, resp_relation=0, resp_id=0, alu_* = 0.
//  - IDLE: grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    req_ready is combinational from req_valid and is nonzero only in IDLE (see CONFIGURATION).
//    On grant: latch slice i into alu_conf/alu_sign/alu_in1/alu_in2, gnt_id<=i,
//    rr_ptr<=(i+1) mod NUM_REQ, state<=EXEC. No valid: stay IDLE, rr_ptr unchanged.
//  - EXEC (one cycle): ALU settles; at posedge capture alu_result/alu_relation into resp_result/
//    resp_relation, resp_id<=gnt_id, resp_valid<=onehot(gnt_id), state<=RESP.
//  - RESP: resp_valid and payload held stable until resp_ready[resp_id]==1; that cycle
//    resp_valid<=0, state<=IDLE. resp_ready bits of other requesters ignored.
//  - Latency: handshake cycle T -> resp_valid high from T+2. Throughput: 1 op / 3 cycles min.
//  - alu_* outputs hold last operands outside EXEC (no toggling); ALUConf passed unchecked;
//    unsupported codes yield whatever ALU returns (0).
//  - Simultaneous requests: exactly one granted per cycle; others wait with req_valid held.
//    Requesters must hold payload stable until their req_ready; dropping req_valid before grant is
//    legal and has no effect.
//  - Fairness: a continuously requesting requester is granted within NUM_REQ grants.
//  - Reset mid-operation (EXEC or RESP): in-flight op discarded, no response issued.
// CONFIGURATION
//  ALU_ARB_OVERLAP_EN defined: in RESP, the cycle resp_ready[resp_id]==1, arbitration also runs
//    (req_ready may assert); on a grant, latch operands and go directly to EXEC (throughput
//    1 op / 2 cycles); rr_ptr updates as in IDLE. No grant -> IDLE.
//  ALU_ARB_OVERLAP_EN undefined: req_ready is 0 outside IDLE; behaviour exactly as above.
// TESTING
//  1 single req: req_valid=01, conf=ADD, in1=5, in2=7 -> req_ready=01 same cycle; 2 cycles later
//    resp_valid=01, resp_result=12, resp_relation=01, resp_id=0.
//  2 contention: req_valid=11 held, after reset -> grants 0,1,0,1 (rr_ptr alternates); each
//    resp_id matches grant order.
//  3 backpressure: SUB 3-5 with resp_ready=0 for 4 cycles -> resp_valid held, result=32'hFFFFFFFE,
//    relation=01 stable; new req_valid on other port not granted until resp_ready=1.
//  4 signed SLT, Sign=1, in1=32'hFFFFFFFF, in2=1 -> resp_result=1; Sign=0 same operands -> 0.
//  5 reset low during RESP -> next cycle resp_valid=0, state IDLE, rr_ptr=0, no stale response.
//  6 ALU_ARB_OVERLAP_EN: back-to-back requests, resp_ready=1 -> grants every 2 cycles;
//    without macro -> every 3 cycles.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Round-robin arbiter that lends one combinational ALU to NUM_REQ requesters.
// A granted request has its operands registered onto alu_*. One cycle later the ALU
// result is captured into the response registers. The response is then held until
// the owning requester accepts it.
// Optional feature macro: ALU_ARB_OVERLAP_EN. When it is defined, the cycle that
// retires a response can also grant the next request, which skips the IDLE cycle.
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [5*NUM_REQ-1:0]    req_conf,
    input  logic [NUM_REQ-1:0]      req_sign,
    input  logic [32*NUM_REQ-1:0]   req_in1,
    input  logic [32*NUM_REQ-1:0]   req_in2,
    output logic [4:0]              alu_conf,
    output logic                    alu_sign,
    output logic [31:0]             alu_in1,
    output logic [31:0]             alu_in2,
    input  logic [31:0]             alu_result,
    input  logic [1:0]              alu_relation,
    output logic [NUM_REQ-1:0]      resp_valid,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [31:0]             resp_result,
    output logic [1:0]              resp_relation,
    output logic [IDW-1:0]          resp_id
);

    localparam int SW = IDW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [IDW-1:0]       r_rr_ptr;
    logic [IDW-1:0]       r_gnt_id;
    logic [4:0]           r_alu_conf;
    logic                 r_alu_sign;
    logic [31:0]          r_alu_in1;
    logic [31:0]          r_alu_in2;
    logic [NUM_REQ-1:0]   r_resp_valid;
    logic [31:0]          r_resp_result;
    logic [1:0]           r_resp_relation;
    logic [IDW-1:0]       r_resp_id;

    logic [4:0]           w_conf_arr [NUM_REQ];
    logic                 w_sign_arr [NUM_REQ];
    logic [31:0]          w_in1_arr  [NUM_REQ];
    logic [31:0]          w_in2_arr  [NUM_REQ];
    logic                 w_found;
    logic [IDW-1:0]       w_win;
    logic [SW-1:0]        w_sum;
    logic                 w_resp_hs;
    logic                 w_arb_en;
    logic                 w_grant;
    logic [IDW-1:0]       w_rr_next;
    logic [NUM_REQ-1:0]   w_gnt_onehot;

    // Unpack the flat per-requester buses into indexable arrays.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign w_conf_arr[gi] = req_conf[5*gi +: 5];
            assign w_sign_arr[gi] = req_sign[gi];
            assign w_in1_arr[gi]  = req_in1[32*gi +: 32];
            assign w_in2_arr[gi]  = req_in2[32*gi +: 32];
        end
    endgenerate

    // Round-robin search: first valid requester starting at r_rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + SW'(k);
            if (w_sum >= SW'(NUM_REQ)) begin
                w_sum = w_sum - SW'(NUM_REQ);
            end
            if (!w_found && req_valid[w_sum[IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[IDW-1:0];
            end
        end
    end

    // The response retires only on the owner's ready bit. Other requesters' ready bits are ignored.
    assign w_resp_hs = (r_state == S_RESP) && resp_ready[r_resp_id];

`ifdef ALU_ARB_OVERLAP_EN
    assign w_arb_en = (r_state == S_IDLE) || w_resp_hs;
`else
    assign w_arb_en = (r_state == S_IDLE);
`endif

    assign w_grant   = w_arb_en && w_found;
    assign w_rr_next = (w_win == IDW'(NUM_REQ - 1)) ? '0 : w_win + IDW'(1);

    // One-hot grant back to the requesters, combinational from req_valid.
    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_win] = 1'b1;
        end
    end

    // One-hot owner mask for the response about to be issued.
    always_comb begin
        w_gnt_onehot = NUM_REQ'(1) << r_gnt_id;
    end

    // Next-state logic: IDLE -> EXEC -> RESP -> IDLE (or RESP -> EXEC when overlapped).
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_next = S_RESP;
            end
            S_RESP: begin
                if (w_resp_hs) begin
                    w_state_next = w_grant ? S_EXEC : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand latch on grant, result capture in EXEC, response retire on owner handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rr_ptr        <= '0;
            r_gnt_id        <= '0;
            r_alu_conf      <= '0;
            r_alu_sign      <= 1'b0;
            r_alu_in1       <= '0;
            r_alu_in2       <= '0;
            r_resp_valid    <= '0;
            r_resp_result   <= '0;
            r_resp_relation <= '0;
            r_resp_id       <= '0;
        end else begin
            if (w_grant) begin
                r_alu_conf <= w_conf_arr[w_win];
                r_alu_sign <= w_sign_arr[w_win];
                r_alu_in1  <= w_in1_arr[w_win];
                r_alu_in2  <= w_in2_arr[w_win];
                r_gnt_id   <= w_win;
                r_rr_ptr   <= w_rr_next;
            end
            if (r_state == S_EXEC) begin
                r_resp_result   <= alu_result;
                r_resp_relation <= alu_relation;
                r_resp_id       <= r_gnt_id;
                r_resp_valid    <= w_gnt_onehot;
            end else if (w_resp_hs) begin
                r_resp_valid <= '0;
            end
        end
    end

    assign alu_conf      = r_alu_conf;
    assign alu_sign      = r_alu_sign;
    assign alu_in1       = r_alu_in1;
    assign alu_in2       = r_alu_in2;
    assign resp_valid    = r_resp_valid;
    assign resp_result   = r_resp_result;
    assign resp_relation = r_resp_relation;
    assign resp_id       = r_resp_id;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter with two requesters.
// The bench also models the shared ALU. Its opcode encoding is local to the bench.
// Its relation output encodes in2 relative to in1: 01 = in2 greater, 00 = in2 smaller, 10 = equal.
// The bench runs table vectors, hand-written corner sequences and a randomized phase.
// The randomized phase is checked against a transaction-level model.
// Build with ALU_ARB_OVERLAP_EN defined to check the overlapped timing.
module tb_alu_share_arbiter;

    localparam int N   = 2;
    localparam int IDW = 1;
`ifdef ALU_ARB_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif
    localparam int SPACING = OVL ? 2 : 3;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4;
    localparam logic [4:0] OP_NOR = 5'd5;
    localparam logic [4:0] OP_SLT = 5'd6;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [5*N-1:0]    req_conf;
    logic [N-1:0]      req_sign;
    logic [32*N-1:0]   req_in1;
    logic [32*N-1:0]   req_in2;
    logic [4:0]        alu_conf;
    logic              alu_sign;
    logic [31:0]       alu_in1;
    logic [31:0]       alu_in2;
    logic [31:0]       alu_result;
    logic [1:0]        alu_relation;
    logic [N-1:0]      resp_valid;
    logic [N-1:0]      resp_ready;
    logic [31:0]       resp_result;
    logic [1:0]        resp_relation;
    logic [IDW-1:0]    resp_id;

    int n_pass  = 0;
    int n_total = 0;

    alu_share_arbiter #(.NUM_REQ(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_conf      (req_conf),
        .req_sign      (req_sign),
        .req_in1       (req_in1),
        .req_in2       (req_in2),
        .alu_conf      (alu_conf),
        .alu_sign      (alu_sign),
        .alu_in1       (alu_in1),
        .alu_in2       (alu_in2),
        .alu_result    (alu_result),
        .alu_relation  (alu_relation),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_result   (resp_result),
        .resp_relation (resp_relation),
        .resp_id       (resp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {relation, result}.
    function automatic logic [33:0] alu_fn(input logic [4:0] c, input logic s,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        lt;
        logic [1:0]  rel;
        lt = s ? ($signed(a) < $signed(b)) : (a < b);
        case (c)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_SLT:  r = {31'd0, lt};
            default: r = 32'd0;
        endcase
        rel = (a == b) ? 2'b10 : (lt ? 2'b01 : 2'b00);
        return {rel, r};
    endfunction

    always_comb {alu_relation, alu_result} = alu_fn(alu_conf, alu_sign, alu_in1, alu_in2);

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] c, input logic s,
                           input logic [31:0] a, input logic [31:0] b);
        req_valid[i]       = v;
        req_conf[5*i +: 5] = c;
        req_sign[i]        = s;
        req_in1[32*i +: 32] = a;
        req_in2[32*i +: 32] = b;
    endtask

    task automatic do_reset();
        tick();
        reset      = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    typedef struct {
        int          port;
        logic [4:0]  conf;
        logic        sign;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [1:0]  rel;
    } vec_t;

    vec_t vt[9];

    // Single isolated operation: grant same cycle, response visible two edges later, then retire.
    task automatic run_op(input vec_t v);
        tick();
        set_req(v.port, 1'b1, v.conf, v.sign, v.a, v.b);
        #1;
        chk("vec_req_ready", req_ready, onehot(v.port));
        tick();
        req_valid = '0;
        #1;
        chk("vec_no_early_resp", resp_valid, '0);
        tick();
        #1;
        chk("vec_resp_valid", resp_valid, onehot(v.port));
        chk("vec_resp_result", resp_result, v.res);
        chk("vec_resp_relation", resp_relation, v.rel);
        chk("vec_resp_id", resp_id, v.port);
        chk("vec_alu_in1_hold", alu_in1, v.a);
        $display("txn vec port=%0d conf=%0d in1=%08h in2=%08h result=%08h rel=%b",
                 v.port, v.conf, v.a, v.b, resp_result, resp_relation);
        resp_ready = '1;
        tick();
        resp_ready = '0;
        #1;
        chk("vec_resp_retired", resp_valid, '0);
    endtask

    // Randomized-phase state.
    bit          rq_v  [N];
    bit          rq_gl [N];
    logic [4:0]  rq_c  [N];
    logic        rq_s  [N];
    logic [31:0] rq_a  [N];
    logic [31:0] rq_b  [N];

    initial begin
        int          g_id[$];
        int          g_cyc[$];
        int          r_id[$];
        logic [31:0] r_res[$];
        bit          got;
        bit          busy;
        int          age;
        int          exp_id;
        logic [31:0] exp_res;
        logic [1:0]  exp_rel;
        int          m_ptr;
        int          n_txn;

        vt[0] = '{0, OP_ADD, 1'b0, 32'd5,          32'd7,          32'd12,         2'b01};
        vt[1] = '{1, OP_SUB, 1'b0, 32'd3,          32'd5,          32'hFFFFFFFE,   2'b01};
        vt[2] = '{0, OP_SLT, 1'b1, 32'hFFFFFFFF,   32'd1,          32'd1,          2'b01};
        vt[3] = '{1, OP_SLT, 1'b0, 32'hFFFFFFFF,   32'd1,          32'd0,          2'b00};
        vt[4] = '{0, OP_AND, 1'b0, 32'h0000F0F0,   32'h0000FF00,   32'h0000F000,   2'b01};
        vt[5] = '{1, OP_OR,  1'b0, 32'h0000000F,   32'h000000F0,   32'h000000FF,   2'b01};
        vt[6] = '{0, OP_XOR, 1'b0, 32'hAAAA5555,   32'hAAAA5555,   32'd0,          2'b10};
        vt[7] = '{1, 5'd31,  1'b0, 32'd9,          32'd3,          32'd0,          2'b00};
        vt[8] = '{0, OP_NOR, 1'b0, 32'd0,          32'd0,          32'hFFFFFFFF,   2'b10};

        reset      = 1'b0;
        req_valid  = '0;
        req_conf   = '0;
        req_sign   = '0;
        req_in1    = '0;
        req_in2    = '0;
        resp_ready = '0;

        // Reset state.
        tick();
        tick();
        #1;
        chk("rst_req_ready", req_ready, '0);
        chk("rst_resp_valid", resp_valid, '0);
        chk("rst_resp_result", resp_result, 32'd0);
        chk("rst_resp_relation", resp_relation, 2'd0);
        chk("rst_resp_id", resp_id, '0);
        chk("rst_alu_ops", {alu_conf, alu_sign, alu_in1, alu_in2}, '0);
        reset = 1'b1;

        // Table vectors.
        for (int k = 0; k < 9; k++) run_op(vt[k]);

        // Contention: both requesters held valid and responses always accepted.
        do_reset();
        set_req(0, 1'b1, OP_ADD, 1'b0, 32'd1, 32'd1);
        set_req(1, 1'b1, OP_ADD, 1'b0, 32'd2, 32'd2);
        resp_ready = '1;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (req_ready != '0) begin
                g_id.push_back(req_ready[1] ? 1 : 0);
                g_cyc.push_back(c);
            end
            if (resp_valid != '0) begin
                r_id.push_back(int'(resp_id));
                r_res.push_back(resp_result);
            end
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            chk("cont_grant_order", (g_id.size() > k) ? g_id[k] : 99, k % 2);
            chk("cont_resp_id", (r_id.size() > k) ? r_id[k] : 99, k % 2);
            chk("cont_resp_result", (r_res.size() > k) ? r_res[k] : 32'hDEAD, (k % 2) ? 32'd4 : 32'd2);
            $display("txn contention k=%0d", k);
        end
        for (int k = 1; k < 4; k++) begin
            chk("cont_grant_spacing", (g_cyc.size() > k) ? g_cyc[k] - g_cyc[k-1] : 99, SPACING);
        end

        // Backpressure: the response is held, and the other port waits until the owner accepts.
        do_reset();
        set_req(0, 1'b1, OP_SUB, 1'b0, 32'd3, 32'd5);
        #1;
        chk("bp_grant0", req_ready, 2'b01);
        tick();
        req_valid = '0;
        tick();
        set_req(1, 1'b1, OP_ADD, 1'b0, 32'd10, 32'd20);
        resp_ready = 2'b10;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_resp_valid_held", resp_valid, 2'b01);
            chk("bp_result_held", resp_result, 32'hFFFFFFFE);
            chk("bp_relation_held", resp_relation, 2'b01);
            chk("bp_no_grant", req_ready, 2'b00);
            tick();
        end
        resp_ready = 2'b01;
        #1;
        chk("bp_grant_on_accept", req_ready, OVL ? 2'b10 : 2'b00);
        tick();
        resp_ready = '0;
        #1;
        chk("bp_resp_retired", resp_valid, '0);
        chk("bp_grant_after", req_ready, OVL ? 2'b00 : 2'b10);
        tick();
        req_valid = '0;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            #1;
            if (resp_valid != '0) got = 1'b1;
            else tick();
        end
        chk("bp_resp_arrived", got, 1'b1);
        chk("bp_port1_resp_id", resp_id, 1);
        chk("bp_port1_result", resp_result, 32'd30);
        $display("txn backpressure port=1 result=%08h", resp_result);
        resp_ready = '1;
        tick();
        resp_ready = '0;

        // Reset while a response is pending: it is dropped and rr_ptr returns to 0.
        do_reset();
        set_req(0, 1'b1, OP_ADD, 1'b0, 32'd4, 32'd4);
        #1;
        chk("rr_grant0", req_ready, 2'b01);
        tick();
        req_valid = '0;
        tick();
        #1;
        chk("rr_resp_pending", resp_valid, 2'b01);
        reset = 1'b0;
        tick();
        #1;
        chk("rr_resp_dropped", resp_valid, '0);
        chk("rr_result_cleared", resp_result, 32'd0);
        chk("rr_alu_cleared", alu_in1, 32'd0);
        reset = 1'b1;
        set_req(0, 1'b1, OP_ADD, 1'b0, 32'd1, 32'd0);
        set_req(1, 1'b1, OP_ADD, 1'b0, 32'd2, 32'd0);
        #1;
        chk("rr_ptr_reset", req_ready, 2'b01);
        tick();
        req_valid = '0;
        resp_ready = '1;
        for (int k = 0; k < 4; k++) tick();
        resp_ready = '0;

        // Reset during EXEC: no response ever appears.
        set_req(1, 1'b1, OP_ADD, 1'b0, 32'd1, 32'd1);
        #1;
        chk("rx_grant1", req_ready, 2'b10);
        tick();
        req_valid = '0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rx_no_stale_resp", resp_valid, '0);
            tick();
        end

        // Randomized traffic against a transaction-level model.
        do_reset();
        busy    = 1'b0;
        age     = 0;
        exp_id  = 0;
        exp_res = '0;
        exp_rel = '0;
        m_ptr   = 0;
        n_txn   = 0;
        for (int i = 0; i < N; i++) begin
            rq_v[i]  = 1'b0;
            rq_gl[i] = 1'b0;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            int best;
            int bestd;
            bit resp_hs;
            bit allowed;
            bit vis;
            tick();
            for (int i = 0; i < N; i++) begin
                if (rq_gl[i]) rq_v[i] = 1'b0;
                rq_gl[i] = 1'b0;
                if (!rq_v[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        rq_v[i] = 1'b1;
                        rq_c[i] = 5'($urandom_range(0, 7));
                        rq_s[i] = 1'($urandom_range(0, 1));
                        rq_a[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                        rq_b[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    rq_v[i] = 1'b0;
                end
                set_req(i, rq_v[i], rq_c[i], rq_s[i], rq_a[i], rq_b[i]);
            end
            resp_ready = N'($urandom_range(0, (1 << N) - 1)) | ($urandom_range(0, 1) ? '1 : '0);
            #1;
            if (busy) age++;
            vis = busy && (age >= 2);
            chk("rnd_resp_valid", resp_valid, vis ? onehot(exp_id) : '0);
            if (vis) begin
                chk("rnd_resp_result", resp_result, exp_res);
                chk("rnd_resp_relation", resp_relation, exp_rel);
                chk("rnd_resp_id", resp_id, exp_id);
            end
            resp_hs = vis && resp_ready[exp_id];
            allowed = !busy || (OVL && resp_hs);
            best  = -1;
            bestd = N;
            for (int i = 0; i < N; i++) begin
                if (rq_v[i] && ((i - m_ptr + N) % N) < bestd) begin
                    bestd = (i - m_ptr + N) % N;
                    best  = i;
                end
            end
            chk("rnd_req_ready", req_ready, (allowed && best >= 0) ? onehot(best) : '0);
            if (resp_hs) begin
                busy = 1'b0;
                n_txn++;
                $display("txn rnd #%0d id=%0d result=%08h rel=%b", n_txn, exp_id, exp_res, exp_rel);
            end
            if (allowed && best >= 0) begin
                busy   = 1'b1;
                age    = 0;
                exp_id = best;
                {exp_rel, exp_res} = alu_fn(rq_c[best], rq_s[best], rq_a[best], rq_b[best]);
                m_ptr  = (best + 1) % N;
                rq_gl[best] = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
